// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the staged reset sequencer.
package reset_seq_pkg;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RELEASE = 2'd2
  } seq_state_t;

  // Width of a saturating counter that must reach max(hold, gap).
  function automatic int cnt_width(input int hold, input int gap);
    int m;
    m = (hold > gap) ? hold : gap;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/reset_sequencer_bit_sync.sv
// Multi-flop synchronizer for a single asynchronous level; clears to 0 on rst.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_chain;

  // Shift the input through the flop chain; bit 0 is the first capture stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], d};
    end
  end

  assign q = r_chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset generator: holds all domain resets for HOLD_CYCLES after a
// request (or its own reset), then releases them bit 0 first, GAP_CYCLES apart.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_DOMAINS = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_async,
  input  logic                   req_sync,
  output logic [NUM_DOMAINS-1:0] rst_out,
  output logic                   seq_busy,
  output logic                   seq_done
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DOMAINS - 1);

  // Request detection
  logic w_sync_q;
  logic r_sync_dly;
  logic w_async_rise;
  logic w_req;

  // Sequencer state
  seq_state_t             r_state;
  seq_state_t             w_state_next;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_next;
  logic [CNT_W-1:0]       w_cnt_inc;
  logic [IDX_W-1:0]       r_idx;
  logic [IDX_W-1:0]       w_idx_next;
  logic [NUM_DOMAINS-1:0] r_rst_out;
  logic [NUM_DOMAINS-1:0] w_rst_out_next;
  logic [NUM_DOMAINS-1:0] w_idx_onehot;
  logic                   r_done;
  logic                   w_done_next;
  logic                   w_hold_end;
  logic                   w_gap_end;
  logic                   w_last_idx;

  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (req_async),
    .q   (w_sync_q)
  );

  // Delayed copy of the synchronized request for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_dly <= 1'b0;
    end else begin
      r_sync_dly <= w_sync_q;
    end
  end

  // A held async level yields a single request; req_sync counts every cycle.
  assign w_async_rise = w_sync_q & ~r_sync_dly;
  assign w_req        = req_sync | w_async_rise;

  // One-hot decode of the next domain to release.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DOMAINS; gi++) begin : g_idx_dec
      assign w_idx_onehot[gi] = (r_idx == IDX_W'(gi));
    end
  endgenerate

  assign w_hold_end = (r_cnt == HOLD_LAST);
  assign w_gap_end  = (r_cnt == GAP_LAST);
  assign w_last_idx = (r_idx == LAST_IDX);
  assign w_cnt_inc  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

  // State register plus counter, release index and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_ASSERT;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_rst_out <= '1;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_idx     <= w_idx_next;
      r_rst_out <= w_rst_out_next;
      r_done    <= w_done_next;
    end
  end

  // Next-state logic; any request restarts the sequence from ASSERT.
  always_comb begin
    w_state_next = r_state;
    if (w_req) begin
      w_state_next = ST_ASSERT;
    end else begin
      case (r_state)
        ST_IDLE:    w_state_next = ST_IDLE;
        ST_ASSERT:  if (w_hold_end) w_state_next = w_last_idx ? ST_IDLE : ST_RELEASE;
        ST_RELEASE: if (w_gap_end && w_last_idx) w_state_next = ST_IDLE;
        default:    w_state_next = ST_IDLE;
      endcase
    end
  end

  // Next values of counter, index, resets and done pulse.
  always_comb begin
    w_cnt_next     = r_cnt;
    w_idx_next     = r_idx;
    w_rst_out_next = r_rst_out;
    w_done_next    = 1'b0;
    if (w_req) begin
      // Restart wins over any release or done due on this edge.
      w_cnt_next     = '0;
      w_idx_next     = '0;
      w_rst_out_next = '1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_cnt_next     = '0;
          w_idx_next     = '0;
          w_rst_out_next = '0;
        end
        ST_ASSERT, ST_RELEASE: begin
          if ((r_state == ST_ASSERT) ? w_hold_end : w_gap_end) begin
            w_rst_out_next = r_rst_out & ~w_idx_onehot;
            w_cnt_next     = '0;
            w_idx_next     = r_idx + 1'b1;
            w_done_next    = w_last_idx;
          end else begin
            w_cnt_next = w_cnt_inc;
          end
        end
        default: begin
          w_cnt_next     = '0;
          w_idx_next     = '0;
          w_rst_out_next = '0;
        end
      endcase
    end
  end

  // Output drive from registered state.
  always_comb begin
    rst_out  = r_rst_out;
    seq_busy = |r_rst_out;
    seq_done = r_done;
  end

endmodule
